// File: rtl/hdp_spi_sequencer_if.sv
// Host request/response port of the HDP SPI sequencer.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_write           : 1 = register write, 0 = register read
//   req_addr/req_wdata  : 7-bit HDP register address, 8-bit write data
//   rsp_valid           : one-cycle pulse per completed host transaction
//   rsp_rdata           : read data (8'hFF after a timed-out transfer)
// master = command logic side, slave = sequencer side.
interface hdp_spi_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (output req_valid, req_write, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/hdp_spi_sequencer.sv
// HDP-1280-2 SPI sequencer. Sole driver of the SPI master's start/Tx lines.
// After reset (and after POWERUP_WAIT cycles) it plays INIT_LEN register
// writes from an external ROM, then serves single host read/writes.
//
// Ports:
//   i_clock, i_reset_n        : clock, async active-low reset
//   init_req                  : rising edge re-runs the init table
//   init_idx / init_entry     : ROM address out / {addr,data} entry in
//   init_done, err            : init completed cleanly / sticky error
//   host (slave modport)      : host request/response port
//   spi_enable, spi_start     : SPI master enable and start_transfer
//   spi_tx_upper/spi_tx_lower : Tx bytes ({rd,addr[6:0]}, data)
//   spi_rx_lower, spi_done    : Rx byte and completion pulse
//
// Optional build macro HDP_INIT_VERIFY_EN: every init write is read back
// and compared; a mismatch sets err and aborts init.
// GAP_CYCLES must be >= 2 (read data is captured during the gap).
module hdp_spi_sequencer #(
  parameter int INIT_LEN       = 16,
  parameter int POWERUP_WAIT   = 1000,
  parameter int GAP_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        init_req,
  output logic [7:0]  init_idx,
  input  logic [15:0] init_entry,
  output logic        init_done,
  hdp_spi_sequencer_if.slave host,
  output logic        err,
  output logic        spi_enable,
  output logic        spi_start,
  output logic [7:0]  spi_tx_upper,
  output logic [7:0]  spi_tx_lower,
  input  logic [7:0]  spi_rx_lower,
  input  logic        spi_done
);

  typedef enum logic [2:0] {PWR_WAIT, FETCH, ISSUE, WAIT_DONE, GAP, IDLE} state_t;

  state_t      state;
  logic [31:0] cnt;        // shared by power-up wait, timeout and gap
  logic        init_req_d;
  logic        init_pend;  // edge seen while busy, serviced in IDLE
  logic        init_run;   // current transaction belongs to the init table
  logic        aborted;    // current transaction timed out
  logic        done_d;     // cycle after spi_done: Rx byte is sampled
  logic        is_read;
  logic [7:0]  rx_q;
`ifdef HDP_INIT_VERIFY_EN
  logic        vphase;     // current init transaction is the readback
  logic [7:0]  vdata;      // data written by the entry being verified
`endif

  logic init_edge, init_any, unused_entry_msb;
  assign init_edge = init_req & ~init_req_d;
  assign init_any  = init_pend | init_edge;
  // Init entries are always writes, so the top address bit is discarded.
  assign unused_entry_msb = init_entry[15];

  assign host.req_ready = (state == IDLE) && !init_any;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= PWR_WAIT;
      cnt            <= '0;
      init_req_d     <= 1'b0;
      init_pend      <= 1'b0;
      init_run       <= 1'b0;
      aborted        <= 1'b0;
      done_d         <= 1'b0;
      is_read        <= 1'b0;
      rx_q           <= '0;
      init_idx       <= '0;
      init_done      <= 1'b0;
      err            <= 1'b0;
      spi_enable     <= 1'b0;
      spi_start      <= 1'b0;
      spi_tx_upper   <= '0;
      spi_tx_lower   <= '0;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
`ifdef HDP_INIT_VERIFY_EN
      vphase         <= 1'b0;
      vdata          <= '0;
`endif
    end else begin
      init_req_d     <= init_req;
      if (init_edge) init_pend <= 1'b1;
      host.rsp_valid <= 1'b0;
      done_d         <= 1'b0;
      if (done_d) rx_q <= spi_rx_lower;

      case (state)
        PWR_WAIT: begin
          if (cnt == 32'(POWERUP_WAIT - 1)) begin
            cnt        <= '0;
            spi_enable <= 1'b1;
            init_idx   <= '0;
            init_run   <= 1'b1;
            state      <= FETCH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        // Tx bytes are loaded here so they lead spi_start by one cycle.
        FETCH: begin
          spi_tx_upper <= {1'b0, init_entry[14:8]};
          spi_tx_lower <= init_entry[7:0];
          is_read      <= 1'b0;
`ifdef HDP_INIT_VERIFY_EN
          vdata        <= init_entry[7:0];
`endif
          state        <= ISSUE;
        end

        ISSUE: begin
          spi_start <= 1'b1;
          cnt       <= '0;
          state     <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (spi_done) begin
            spi_start <= 1'b0;
            cnt       <= '0;
            done_d    <= 1'b1;
            state     <= GAP;
          end else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            spi_start <= 1'b0;
            err       <= 1'b1;
            aborted   <= 1'b1;
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        GAP: begin
          if (cnt != 32'(GAP_CYCLES - 1)) begin
            cnt <= cnt + 32'd1;
          end else begin
            cnt <= '0;
`ifdef HDP_INIT_VERIFY_EN
            vphase <= 1'b0;
`endif
            if (!init_run) begin
              host.rsp_valid <= 1'b1;
              if (aborted)      host.rsp_rdata <= 8'hFF;
              else if (is_read) host.rsp_rdata <= rx_q;
              state <= IDLE;
            end else if (aborted) begin
              init_run <= 1'b0;
              state    <= IDLE;
`ifdef HDP_INIT_VERIFY_EN
            end else if (!vphase) begin
              // Read back the address just written.
              vphase       <= 1'b1;
              is_read      <= 1'b1;
              spi_tx_upper <= {1'b1, spi_tx_upper[6:0]};
              spi_tx_lower <= 8'h00;
              state        <= ISSUE;
            end else if (rx_q != vdata) begin
              err      <= 1'b1;
              init_run <= 1'b0;
              state    <= IDLE;
`endif
            end else if (init_idx < 8'(INIT_LEN - 1)) begin
              init_idx <= init_idx + 8'd1;
              state    <= FETCH;
            end else begin
              init_run  <= 1'b0;
              init_done <= ~err;
              state     <= IDLE;
            end
          end
        end

        IDLE: begin
          aborted <= 1'b0;
          if (init_any) begin
            // A pending re-init wins over a same-cycle host request.
            init_pend <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
            init_idx  <= '0;
            init_run  <= 1'b1;
            state     <= FETCH;
          end else if (host.req_valid) begin
            spi_tx_upper <= {~host.req_write, host.req_addr};
            spi_tx_lower <= host.req_write ? host.req_wdata : 8'h00;
            is_read      <= ~host.req_write;
            state        <= ISSUE;
          end
        end

        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hdp_spi_sequencer.sv
// Self-checking bench for hdp_spi_sequencer: an SPI device model answers
// transfers with random latency from a register array; expected transfers
// and responses are queued from the register-access rules and checked by a
// monitor on every falling edge, plus literal expectations for known cases.
`timescale 1ns/1ps
module tb_hdp_spi_sequencer;
  localparam int INIT_LEN = 3;
  localparam int PW       = 20;
  localparam int GAP      = 8;
  localparam int TMO      = 60;
`ifdef HDP_INIT_VERIFY_EN
  localparam int VSTEP = 2;
`else
  localparam int VSTEP = 1;
`endif

  logic        i_clock = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        init_req = 1'b0;
  logic [7:0]  init_idx;
  logic [15:0] init_entry;
  logic        init_done, err, spi_enable, spi_start;
  logic [7:0]  spi_tx_upper, spi_tx_lower;
  logic [7:0]  spi_rx_lower = 8'h00;
  logic        spi_done = 1'b0;
  logic [15:0] rom [0:3];

  hdp_spi_sequencer_if host();

  assign init_entry = rom[init_idx[1:0]];

  hdp_spi_sequencer #(.INIT_LEN(INIT_LEN), .POWERUP_WAIT(PW),
                      .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .init_req(init_req),
    .init_idx(init_idx), .init_entry(init_entry), .init_done(init_done),
    .host(host), .err(err), .spi_enable(spi_enable), .spi_start(spi_start),
    .spi_tx_upper(spi_tx_upper), .spi_tx_lower(spi_tx_lower),
    .spi_rx_lower(spi_rx_lower), .spi_done(spi_done));

  always #5 i_clock = ~i_clock;

  int          n_pass = 0, n_chk = 0;
  logic [15:0] exp_tx[$];
  logic [15:0] tx_log[$];
  logic [8:0]  exp_rsp[$];     // {is_read, expected rdata}
  logic [7:0]  ref_mem [0:127];
  logic [7:0]  dev_mem [0:127];
  logic        hang = 1'b0;
  logic [7:0]  corrupt_addr = 8'hFF;
  int          last_hi = 0;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d at %0t", nm, act, lo, hi, $time);
  endtask

  task automatic push_init();
    for (int i = 0; i < INIT_LEN; i++) begin
      exp_tx.push_back({1'b0, rom[i][14:8], rom[i][7:0]});
      ref_mem[rom[i][14:8]] = rom[i][7:0];
      if (VSTEP == 2) exp_tx.push_back({1'b1, rom[i][14:8], 8'h00});
    end
  endtask

  task automatic start_req(input logic w, input logic [6:0] a, input logic [7:0] d);
    host.req_valid = 1'b1; host.req_write = w; host.req_addr = a; host.req_wdata = d;
  endtask

  // Waits for acceptance, queues what the transfer and response must be.
  task automatic finish_req(input bit chk_done);
    int n;
    logic w; logic [6:0] a; logic [7:0] d;
    n = 0;
    #1;
    while (!host.req_ready && n < 5000) begin @(negedge i_clock); #1; n++; end
    if (n >= 5000) begin
      chk_eq("req_accept_timeout", 32'(host.req_ready), 32'd1);
      host.req_valid = 1'b0;
    end else begin
      if (chk_done) chk_eq("init_done_when_ready", 32'(init_done), 32'd1);
      w = host.req_write; a = host.req_addr; d = host.req_wdata;
      exp_tx.push_back({~w, a, w ? d : 8'h00});
      if (w) ref_mem[a] = d;
      exp_rsp.push_back(w ? 9'h000 : {1'b1, hang ? 8'hFF : ref_mem[a]});
      @(posedge i_clock); #1;
      host.req_valid = 1'b0;
    end
  endtask

  task automatic do_req(input logic w, input logic [6:0] a, input logic [7:0] d);
    @(negedge i_clock);
    start_req(w, a, d);
    finish_req(1'b0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (exp_rsp.size() != 0 && n < 3000) begin @(negedge i_clock); n++; end
    chk_eq("rsp_outstanding", 32'(exp_rsp.size()), 32'd0);
    @(negedge i_clock);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge i_clock); #1;
    while (!host.req_ready && n < 5000) begin @(negedge i_clock); #1; n++; end
    chk_eq("reach_idle", 32'(host.req_ready), 32'd1);
  endtask

  // Monitor: transfer contents, gap, stability, timeout length, responses.
  initial begin
    logic prev_start, prev_rsp;
    logic [15:0] cur_tx, e;
    logic [8:0]  r;
    int low_cnt, hi_cnt, since_rst;
    prev_start = 0; prev_rsp = 0; low_cnt = 1000; hi_cnt = 0; since_rst = 0; cur_tx = '0;
    forever begin
      @(negedge i_clock);
      if (!i_reset_n) begin
        prev_start = 0; prev_rsp = 0; low_cnt = 1000; since_rst = 0;
      end else begin
        since_rst++;
        if (since_rst < PW) chk_eq("enable_low_in_pwr_wait", 32'(spi_enable), 32'd0);
        if (spi_start && !prev_start) begin
          tx_log.push_back({spi_tx_upper, spi_tx_lower});
          chk_rng("gap_before_start", low_cnt, GAP, 1 << 30);
          chk_eq("enable_at_start", 32'(spi_enable), 32'd1);
          if (tx_log.size() == 1) chk_rng("powerup_wait", since_rst, PW, 1 << 30);
          if (exp_tx.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_start: got %h, expected no transfer at %0t",
                     {spi_tx_upper, spi_tx_lower}, $time);
          end else begin
            e = exp_tx.pop_front();
            chk_eq("start_tx", 32'({spi_tx_upper, spi_tx_lower}), 32'(e));
          end
          cur_tx = {spi_tx_upper, spi_tx_lower};
          hi_cnt = 0;
        end
        if (spi_start) begin
          hi_cnt++;
          if (prev_start) chk_eq("tx_stable", 32'({spi_tx_upper, spi_tx_lower}), 32'(cur_tx));
          low_cnt = 0;
        end else begin
          if (prev_start) begin
            last_hi = hi_cnt;
            chk_rng("start_high_len", hi_cnt, 1, TMO);
          end
          low_cnt++;
        end
        if (host.rsp_valid) begin
          chk_eq("rsp_single_cycle", 32'(prev_rsp), 32'd0);
          if (exp_rsp.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: got rsp_valid, expected none at %0t", $time);
          end else begin
            r = exp_rsp.pop_front();
            if (r[8]) chk_eq("rsp_rdata", 32'(host.rsp_rdata), 32'(r[7:0]));
          end
        end
        prev_rsp   = host.rsp_valid;
        prev_start = spi_start;
      end
    end
  end

  // SPI device model: register array, random completion latency.
  initial begin
    int lat; logic busy, dprev; logic [6:0] a;
    lat = 0; busy = 0; dprev = 0;
    forever begin
      @(negedge i_clock);
      spi_done = 1'b0;
      if (!i_reset_n) begin
        busy = 0; dprev = 0;
      end else begin
        if (spi_start && !dprev) begin
          a = spi_tx_upper[6:0];
          if (!spi_tx_upper[7]) begin
            dev_mem[a] = spi_tx_lower;
            spi_rx_lower = 8'($urandom);
          end else begin
            spi_rx_lower = dev_mem[a] ^ (({1'b0, a} == corrupt_addr) ? 8'h01 : 8'h00);
          end
          if (!hang) begin busy = 1; lat = $urandom_range(1, 6); end
        end else if (busy) begin
          lat--;
          if (lat == 0) begin spi_done = 1'b1; busy = 0; end
        end
        dprev = spi_start;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int mark;
    logic [7:0] v;
    rom[0] = 16'h01A5; rom[1] = 16'h023C; rom[2] = 16'h7F00; rom[3] = 16'h0000;
    for (int i = 0; i < 128; i++) begin v = 8'($urandom); ref_mem[i] = v; dev_mem[i] = v; end
    host.req_valid = 1'b0; host.req_write = 1'b0; host.req_addr = '0; host.req_wdata = '0;

    // Reset values
    repeat (3) @(negedge i_clock);
    chk_eq("rst_spi_enable", 32'(spi_enable), 32'd0);
    chk_eq("rst_spi_start", 32'(spi_start), 32'd0);
    chk_eq("rst_tx", 32'({spi_tx_upper, spi_tx_lower}), 32'd0);
    chk_eq("rst_init_idx", 32'(init_idx), 32'd0);
    chk_eq("rst_init_done", 32'(init_done), 32'd0);
    chk_eq("rst_err", 32'(err), 32'd0);
    chk_eq("rst_req_ready", 32'(host.req_ready), 32'd0);
    chk_eq("rst_rsp", 32'({host.rsp_valid, host.rsp_rdata}), 32'd0);

    // Init sequence, host write held off until it completes
    push_init();
    @(posedge i_clock); #2 i_reset_n = 1'b1;
    repeat (5) @(negedge i_clock);
    start_req(1'b1, 7'h10, 8'h77);
    finish_req(1'b1);
    chk_eq("init_tx0", 32'(tx_log[0]), 32'h01A5);
    chk_eq("init_tx1", 32'(tx_log[VSTEP]), 32'h023C);
    chk_eq("init_tx2", 32'(tx_log[2*VSTEP]), 32'h7F00);
    chk_eq("init_err", 32'(err), 32'd0);
    wait_rsp();
    chk_eq("held_write_tx", 32'(tx_log[tx_log.size()-1]), 32'h1077);

    // Host read of 0x10 returning 0x5A
    do_req(1'b1, 7'h10, 8'h5A); wait_rsp();
    do_req(1'b0, 7'h10, 8'h00); wait_rsp();
    chk_eq("read_tx", 32'(tx_log[tx_log.size()-1]), 32'h9000);
    chk_eq("read_rdata", 32'(host.rsp_rdata), 32'h5A);

    // Random host traffic
    for (int i = 0; i < 20; i++) begin
      do_req(1'($urandom), 7'($urandom), 8'($urandom));
      wait_rsp();
    end

    // Host read times out
    hang = 1'b1;
    do_req(1'b0, 7'h22, 8'h00); wait_rsp();
    hang = 1'b0;
    chk_eq("tmo_err", 32'(err), 32'd1);
    chk_eq("tmo_rdata", 32'(host.rsp_rdata), 32'hFF);
    chk_eq("tmo_len", 32'(last_hi), 32'(TMO));

    // Init times out on its first entry
    hang = 1'b1;
    @(negedge i_clock);
    init_req = 1'b1;
    exp_tx.push_back({1'b0, rom[0][14:8], rom[0][7:0]});
    ref_mem[rom[0][14:8]] = rom[0][7:0];
    @(posedge i_clock); #1 init_req = 1'b0;
    @(negedge i_clock);
    chk_eq("reinit_clears_err", 32'(err), 32'd0);
    wait_idle();
    hang = 1'b0;
    chk_eq("init_tmo_err", 32'(err), 32'd1);
    chk_eq("init_tmo_done", 32'(init_done), 32'd0);
    chk_eq("init_tmo_starts", 32'(exp_tx.size()), 32'd0);
    do_req(1'b1, 7'h45, 8'h12); wait_rsp();
    chk_eq("err_sticky", 32'(err), 32'd1);

    // init_req and req_valid together: init first
    rom[0] = 16'h8155;
    @(negedge i_clock);
    init_req = 1'b1;
    push_init();
    start_req(1'b1, 7'h33, 8'hC4);
    mark = tx_log.size();
    @(posedge i_clock); #1 init_req = 1'b0;
    @(negedge i_clock);
    chk_eq("restart_err", 32'(err), 32'd0);
    chk_eq("restart_done", 32'(init_done), 32'd0);
    chk_eq("restart_ready", 32'(host.req_ready), 32'd0);
    finish_req(1'b1);
    wait_rsp();
    chk_eq("restart_first_tx", 32'(tx_log[mark]), 32'h0155);
    chk_eq("restart_req_after", 32'(tx_log[mark + 3*VSTEP]), 32'h33C4);
    chk_eq("restart_done_end", 32'(init_done), 32'd1);
    chk_eq("restart_err_end", 32'(err), 32'd0);

`ifdef HDP_INIT_VERIFY_EN
    // Readback of entry 1 corrupted
    rom[0] = 16'h01A5;
    corrupt_addr = 8'h02;
    @(negedge i_clock);
    init_req = 1'b1;
    exp_tx.push_back(16'h01A5); exp_tx.push_back(16'h8100);
    exp_tx.push_back(16'h023C); exp_tx.push_back(16'h8200);
    ref_mem[7'h01] = 8'hA5; ref_mem[7'h02] = 8'h3C;
    @(posedge i_clock); #1 init_req = 1'b0;
    wait_idle();
    repeat (4*GAP) @(negedge i_clock);
    corrupt_addr = 8'hFF;
    chk_eq("verify_err", 32'(err), 32'd1);
    chk_eq("verify_done", 32'(init_done), 32'd0);
    chk_eq("verify_starts", 32'(exp_tx.size()), 32'd0);
    chk_eq("verify_last_tx", 32'(tx_log[tx_log.size()-1]), 32'h8200);
`endif

    // Reset mid-transaction drops start/enable without a clock edge
    hang = 1'b1;
    do_req(1'b0, 7'h05, 8'h00);
    for (int n = 0; n < 20 && !spi_start; n++) @(negedge i_clock);
    chk_eq("midrst_start_seen", 32'(spi_start), 32'd1);
    @(posedge i_clock); #2 i_reset_n = 1'b0;
    #1;
    chk_eq("midrst_start", 32'(spi_start), 32'd0);
    chk_eq("midrst_enable", 32'(spi_enable), 32'd0);
    chk_eq("midrst_err", 32'(err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
